// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI command sequencer: command-word
// layout, opcodes, FSM state type and the command/expected-response tables.
package spi_pkg;

    localparam int OP_W      = 8;
    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 8;
    localparam int CMD_W     = OP_W + ADDR_W + DATA_W;
    localparam int IDX_W     = 8;
    localparam int TBL_DEPTH = 8;

    localparam logic [OP_W-1:0] OP_WRITE = 8'h02;
    localparam logic [OP_W-1:0] OP_READ  = 8'h03;
    localparam logic [OP_W-1:0] OP_WRDI  = 8'h04;
    localparam logic [OP_W-1:0] OP_RDSR  = 8'h05;
    localparam logic [OP_W-1:0] OP_WREN  = 8'h06;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    // Runs longer than TBL_DEPTH wrap around the tables.
    localparam logic [CMD_W-1:0] CMD_TABLE [0:TBL_DEPTH-1] = '{
        {OP_WREN,  8'h00, 8'h00},
        {OP_WRITE, 8'h10, 8'hA5},
        {OP_WRITE, 8'h11, 8'h5A},
        {OP_RDSR,  8'h00, 8'h00},
        {OP_READ,  8'h10, 8'h00},
        {OP_READ,  8'h11, 8'h00},
        {OP_READ,  8'h12, 8'h00},
        {OP_WRDI,  8'h00, 8'h00}
    };

    localparam logic [DATA_W-1:0] EXP_TABLE [0:TBL_DEPTH-1] = '{
        8'h00, 8'h01, 8'h02, 8'h80, 8'hA5, 8'h5A, 8'h3C, 8'hC3
    };

endpackage

// File: rtl/spi_cmd_rom.sv
// Combinational lookup of the command word and expected response byte
// for independent transmit and receive indices.
module spi_cmd_rom
    import spi_pkg::*;
(
    input  logic [IDX_W-1:0]  cmd_idx,
    input  logic [IDX_W-1:0]  exp_idx,
    output logic [CMD_W-1:0]  cmd_word,
    output logic [DATA_W-1:0] exp_byte
);

    localparam int TW = $clog2(TBL_DEPTH);

    logic [TW-1:0] cmd_sel;
    logic [TW-1:0] exp_sel;

    assign cmd_sel  = TW'(cmd_idx % IDX_W'(TBL_DEPTH));
    assign exp_sel  = TW'(exp_idx % IDX_W'(TBL_DEPTH));
    assign cmd_word = CMD_TABLE[cmd_sel];
    assign exp_byte = EXP_TABLE[exp_sel];

endmodule

// File: rtl/spi_cmd_seq.sv
// Issues NUM_CMDS command words to the SPI command FIFO while concurrently
// draining and checking the response FIFO; aborts on response inactivity.
module spi_cmd_seq
    import spi_pkg::*;
#(
    parameter int NUM_CMDS    = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    input  logic              in_full,
    output logic              in_wr_en,
    output logic [CMD_W-1:0]  in_din,
    input  logic              out_empty,
    output logic              out_rd_en,
    input  logic [DATA_W-1:0] out_dout,
    output logic [15:0]       err_count
);

    localparam int               TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDX_W-1:0] N_IDX   = IDX_W'(NUM_CMDS);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  tx_idx, rx_idx;
    logic [TO_W-1:0]   to_cnt;
    logic [DATA_W-1:0] exp_byte;
    logic              start_ok, rx_last, to_hit;

    spi_cmd_rom u_rom (
        .cmd_idx  (tx_idx),
        .exp_idx  (rx_idx),
        .cmd_word (in_din),
        .exp_byte (exp_byte)
    );

    assign start_ok = start && (state != S_RUN);
    assign rx_last  = (rx_idx == N_IDX);
    assign busy     = (state == S_RUN);
    assign done     = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        in_wr_en  = 1'b0;
        out_rd_en = 1'b0;
        to_hit    = 1'b0;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_RUN;
            S_RUN: begin
                in_wr_en  = (tx_idx < N_IDX) && !in_full;
                out_rd_en = (rx_idx < N_IDX) && !out_empty;
                // Normal completion wins over a timeout landing in the same cycle.
                to_hit    = !rx_last && !out_rd_en && (to_cnt == TO_LAST);
                if (rx_last || to_hit) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            tx_idx    <= '0;
            rx_idx    <= '0;
            to_cnt    <= '0;
            err_count <= '0;
            timeout   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                tx_idx    <= '0;
                rx_idx    <= '0;
                to_cnt    <= '0;
                err_count <= '0;
                timeout   <= 1'b0;
            end else if (state == S_RUN) begin
                if (in_wr_en) tx_idx <= tx_idx + 1'b1;
                if (out_rd_en) begin
                    rx_idx <= rx_idx + 1'b1;
                    to_cnt <= '0;
                end else if (!rx_last) begin
                    to_cnt <= to_cnt + 1'b1;
                end
                if (out_rd_en && (out_dout != exp_byte) && (err_count != 16'hFFFF))
                    err_count <= err_count + 16'd1;
                if (to_hit) timeout <= 1'b1;
            end
        end
    end

endmodule
